dual_key_debounce: RTL and testbench

- Two-channel input conditioner feeding the NAND gate stage (its `a` and `b` inputs).
- Each channel takes a raw asynchronous level, such as a push-button or DIP switch, and synchronises it into the `clk` domain.
- It rejects bounce and glitches, then presents a clean, stable level plus single-cycle rise and fall pulses.
- Outputs `a_o` and `b_o` connect directly to the downstream gate.

---
 rtl/dual_key_debounce_pkg.sv | 9 +
 rtl/key_debounce_ch.sv | 52 +++++
 rtl/dual_key_debounce.sv | 28 ++
 tb/tb_dual_key_debounce.sv | 131 +++++++++++++
 4 files changed

// File: rtl/dual_key_debounce_pkg.sv
// dual_key_debounce_pkg: shared FSM encoding and debounce defaults
package dual_key_debounce_pkg;
  typedef enum logic {S_STABLE = 1'b0, S_COUNT = 1'b1} state_t;
  // 10 ms at 50 MHz
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;
  localparam int unsigned CNT_W_DEFAULT = 20;
  // Short window so simulations reach acceptance in a handful of cycles
  localparam int unsigned DEBOUNCE_SIM = 4;
endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - 2-flop synchroniser, stability FSM, rise/fall pulses
// clk, rst_n (async, active low) | key_in raw async level
// level_o debounced level | rise_o / fall_o one-cycle pulses on level_o 0->1 / 1->0
module key_debounce_ch
  import dual_key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter logic RST_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic sync1, sync2, out_d, rise_d, fall_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= RST_LEVEL;
      sync2 <= RST_LEVEL;
      state_q <= S_STABLE;
      cnt_q <= '0;
      level_o <= RST_LEVEL;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_o <= out_d;
      rise_o <= rise_d;
      fall_o <= fall_d;
    end
  // Accept only once the differing level has been seen on the terminal count;
  // any return to the current level abandons the attempt silently.
  logic diff, accept;
  assign diff = sync2 != level_o;
  assign accept = state_q == S_COUNT && diff && cnt_q == LAST;
  always_comb begin
    state_d = diff && !accept ? S_COUNT : S_STABLE;
    cnt_d = state_q == S_COUNT && diff && !accept ? cnt_q + 1'b1 : '0;
    out_d = accept ? sync2 : level_o;
    rise_d = accept && sync2;
    fall_d = accept && !sync2;
  end
endmodule

// File: rtl/dual_key_debounce.sv
// dual_key_debounce: two independent debounced key channels feeding a NAND stage
// clk, rst_n (async, active low) | key_a_in, key_b_in raw async levels
// a_o, b_o debounced levels | a_rise_o, a_fall_o, b_rise_o, b_fall_o edge pulses
module dual_key_debounce
  import dual_key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter logic RST_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_a_in,
  input  logic key_b_in,
  output logic a_o,
  output logic b_o,
  output logic a_rise_o,
  output logic a_fall_o,
  output logic b_rise_o,
  output logic b_fall_o
);
  key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_LEVEL(RST_LEVEL)) u_a (
    .clk(clk), .rst_n(rst_n), .key_in(key_a_in), .level_o(a_o), .rise_o(a_rise_o), .fall_o(a_fall_o)
  );
  key_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .RST_LEVEL(RST_LEVEL)) u_b (
    .clk(clk), .rst_n(rst_n), .key_in(key_b_in), .level_o(b_o), .rise_o(b_rise_o), .fall_o(b_fall_o)
  );
endmodule

// File: tb/tb_dual_key_debounce.sv
// tb_dual_key_debounce: directed + random checks of dual_key_debounce against a streak-length model
module tb_dual_key_debounce;
  import dual_key_debounce_pkg::*;
  localparam int N = DEBOUNCE_SIM;
  logic clk = 1'b0, rst_n = 1'b0, key_a_in = 1'b0, key_b_in = 1'b0;
  logic a_o, b_o, a_rise_o, a_fall_o, b_rise_o, b_fall_o;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  dual_key_debounce #(.DEBOUNCE_CYCLES(N), .CNT_W(3), .RST_LEVEL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key_a_in(key_a_in), .key_b_in(key_b_in),
    .a_o(a_o), .b_o(b_o), .a_rise_o(a_rise_o), .a_fall_o(a_fall_o),
    .b_rise_o(b_rise_o), .b_fall_o(b_fall_o)
  );
  // Model: the raw level reaches the decision point two edges late; a level is
  // accepted once it has disagreed with the output for N+1 consecutive samples.
  logic [1:0] m_s1, m_s2, m_out, m_rise, m_fall;
  int m_run [2];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_out = 2'b11; m_rise = 2'b00; m_fall = 2'b00;
      m_run[0] = 0; m_run[1] = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_rise[c] = 1'b0;
        m_fall[c] = 1'b0;
        if (m_s2[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == N + 1) begin
            m_out[c] = m_s2[c];
            m_rise[c] = m_s2[c];
            m_fall[c] = !m_s2[c];
            m_run[c] = 0;
          end
        end else m_run[c] = 0;
      end
      m_s2 = m_s1;
      m_s1 = {key_b_in, key_a_in};
    end
  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("a_o", a_o, m_out[0]);
      chk("b_o", b_o, m_out[1]);
      chk("a_rise", a_rise_o, m_rise[0]);
      chk("a_fall", a_fall_o, m_fall[0]);
      chk("b_rise", b_rise_o, m_rise[1]);
      chk("b_fall", b_fall_o, m_fall[1]);
    end
  endtask
  initial begin
    cyc(3);
    chk("rst_a_o", a_o, 1'b1);
    chk("rst_b_o", b_o, 1'b1);
    chk("rst_pulses", a_rise_o | a_fall_o | b_rise_o | b_fall_o, 1'b0);
    rst_n = 1'b1;
    cyc(N + 2);
    chk("post_rst_a_hold", a_o, 1'b1);
    cyc(1);
    chk("post_rst_a_fall", a_o, 1'b0);
    chk("post_rst_a_pulse", a_fall_o, 1'b1);
    chk("post_rst_b_pulse", b_fall_o, 1'b1);
    cyc(1);
    chk("post_rst_pulse_end", a_fall_o | b_fall_o, 1'b0);
    key_a_in = 1'b1; key_b_in = 1'b1;
    cyc(10);
    key_a_in = 1'b0;
    cyc(N + 2);
    chk("press_hold", a_o, 1'b1);
    cyc(1);
    chk("press_a_o", a_o, 1'b0);
    chk("press_pulse", a_fall_o, 1'b1);
    chk("press_b_o", b_o, 1'b1);
    chk("press_nand", ~(a_o & b_o), 1'b1);
    cyc(1);
    chk("press_pulse_end", a_fall_o, 1'b0);
    key_a_in = 1'b1;
    cyc(10);
    for (int i = 0; i < 4; i++) begin
      key_a_in = i[0];
      cyc(2);
    end
    key_a_in = 1'b1;
    cyc(10);
    chk("bounce_a_o", a_o, 1'b1);
    key_a_in = 1'b0; cyc(1);
    key_a_in = 1'b1; cyc(1);
    key_a_in = 1'b0;
    cyc(N + 2);
    chk("settle_hold", a_o, 1'b1);
    cyc(1);
    chk("settle_a_o", a_o, 1'b0);
    chk("settle_pulse", a_fall_o, 1'b1);
    key_a_in = 1'b1;
    cyc(10);
    key_a_in = 1'b0; key_b_in = 1'b0;
    cyc(N + 3);
    chk("simul_a_fall", a_fall_o, 1'b1);
    chk("simul_b_fall", b_fall_o, 1'b1);
    key_a_in = 1'b1; key_b_in = 1'b1;
    cyc(N + 3);
    chk("simul_a_rise", a_rise_o, 1'b1);
    chk("simul_b_rise", b_rise_o, 1'b1);
    cyc(4);
    key_a_in = 1'b0;
    cyc(5);
    rst_n = 1'b0;
    cyc(2);
    chk("midrst_a_o", a_o, 1'b1);
    chk("midrst_pulse", a_fall_o, 1'b0);
    rst_n = 1'b1;
    cyc(N + 2);
    chk("midrst_hold", a_o, 1'b1);
    cyc(1);
    chk("midrst_fall", a_o, 1'b0);
    for (int s = 0; s < 80; s++) begin
      key_a_in = 1'($urandom_range(0, 1));
      key_b_in = 1'($urandom_range(0, 1));
      cyc($urandom_range(1, 9));
    end
    cyc(10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
